// File: rtl/fetch_queue.sv
// Instruction-fetch front end: req/ack fetch engine feeding a small FIFO of {instruction, PC+4}
// toward the IF/ID buffer, with branch-redirect squash of queued and in-flight words.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        stall,
    output logic        out_valid,
    output logic [31:0] out_ins,
    output logic [31:0] out_pc4
);

    localparam int unsigned     PW       = $clog2(DEPTH);
    localparam logic [PW:0]     CNT_FULL = (PW + 1)'(DEPTH);
    localparam logic [PW:0]     CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   addr_q, addr_d;
    logic          req_q, req_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;

    logic [31:0]   ins_mem [DEPTH];
    logic [31:0]   pc4_mem [DEPTH];

    logic          ack;
    logic          push;
    logic          pop;
    logic          flush;
    logic [31:0]   target;
    logic [PW:0]   count_after_push;

    assign ack       = req_q & imem_ack;
    assign flush     = redirect;
    assign target    = redirect_pc & 32'hFFFF_FFFC;
    assign out_valid = (count_q != '0);
    // A redirect cancels any same-cycle pop along with the flush.
    assign pop       = out_valid & ~stall & ~flush;
    assign count_after_push = pop ? count_q : count_q + CNT_ONE;

    // Fetch sequencer: redirect wins over everything, an in-flight fetch is never abandoned
    // (DROP swallows its ack) so the memory always sees a completed handshake.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        push       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    fetch_pc_d = target;
                    addr_d     = target;
                    req_d      = 1'b1;
                    state_d    = S_WAIT;
                end else if (count_q < CNT_FULL) begin
                    addr_d  = fetch_pc_q;
                    req_d   = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    fetch_pc_d = target;
                    if (ack) begin
                        addr_d = target;
                    end else begin
                        state_d = S_DROP;
                    end
                end else if (ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    if (count_after_push < CNT_FULL) begin
                        addr_d = fetch_pc_q + 32'd4;
                    end else begin
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (redirect) begin
                    fetch_pc_d = target;
                end
                if (ack) begin
                    addr_d  = redirect ? target : fetch_pc_q;
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; out_valid gates every read so stale data never escapes.
    always_ff @(posedge clk) begin
        if (push) begin
            ins_mem[wr_ptr_q] <= imem_data;
            pc4_mem[wr_ptr_q] <= addr_q + 32'd4;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign out_ins   = out_valid ? ins_mem[rd_ptr_q] : 32'h0;
    assign out_pc4   = out_valid ? pc4_mem[rd_ptr_q] : 32'h0;

endmodule
